// File: rtl/player_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// player_ctrl_pkg
// Shared constants and types for the player-position controller.
//   - Visible area and sprite half-extents used for position clamping
//   - Reset position of the sprite centre
//   - Controller FSM state type
//   - clamp_axis: saturates a signed candidate coordinate into [lo, hi]
// -----------------------------------------------------------------------------
package player_ctrl_pkg;

    localparam int PLAYER_HALF_W = 10;
    localparam int PLAYER_HALF_H = 20;
    localparam int PLAYER_X0     = 320;
    localparam int PLAYER_Y0     = 400;
    localparam int H_VISIBLE     = 640;
    localparam int V_VISIBLE     = 480;

    // Clamp bounds in the 12-bit signed domain used for candidate arithmetic
    localparam logic signed [11:0] X_MIN = 12'(PLAYER_HALF_W);
    localparam logic signed [11:0] X_MAX = 12'(H_VISIBLE - PLAYER_HALF_W);
    localparam logic signed [11:0] Y_MIN = 12'(PLAYER_HALF_H);
    localparam logic signed [11:0] Y_MAX = 12'(V_VISIBLE - PLAYER_HALF_H);

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        CALC,
        COMMIT
    } ctrl_state_t;

    // A negative candidate (underflow) is below lo and therefore saturates
    // to lo rather than wrapping to a large unsigned value.
    function automatic logic [9:0] clamp_axis(input logic signed [11:0] cand,
                                              input logic signed [11:0] lo,
                                              input logic signed [11:0] hi);
        logic signed [11:0] res;
        if (cand < lo) begin
            res = lo;
        end else if (cand > hi) begin
            res = hi;
        end else begin
            res = cand;
        end
        return res[9:0];
    endfunction

endpackage

// File: rtl/player_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a consecutive-mismatch debounce counter.
// Ports:
//   pixel_clk  in   clock
//   reset      in   synchronous active-high reset
//   raw        in   asynchronous active-high button
//   level      out  debounced button level
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic pixel_clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] count;

    // The level only flips once the synchronised input has disagreed with it
    // for DEBOUNCE_CYCLES cycles in a row; a single agreeing cycle restarts
    // the count, so short glitches never reach the output.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            count  <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b != level) begin
                if (count == LAST) begin
                    level <= sync_b;
                    count <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// -----------------------------------------------------------------------------
// player_ctrl
// Per-frame sprite position controller. Buttons are synchronised and
// debounced; on each vsync assertion edge a new position is computed,
// clamped to the visible area and committed during vertical blanking.
// Ports:
//   pixel_clk    in   pixel clock, all logic on rising edge
//   reset        in   synchronous active-high reset
//   vsync        in   frame sync (synchronous to pixel_clk)
//   enable       in   movement enable, position holds when low
//   btn_left/right/up/down  in  raw active-high buttons
//   player_x     out  10-bit sprite centre x
//   player_y     out  10-bit sprite centre y
//   frame_count  out  16-bit frames committed since reset (wraps)
//   frame_tick   out  one-cycle pulse following each commit
// -----------------------------------------------------------------------------
module player_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int   STEP            = 2,
    parameter int   DEBOUNCE_CYCLES = 250000,
    parameter logic VSYNC_ACTIVE    = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        enable,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [9:0]  player_x,
    output logic [9:0]  player_y,
    output logic [15:0] frame_count,
    output logic        frame_tick
);

    localparam logic signed [11:0] STEP_S = 12'(STEP);

    logic deb_left, deb_right, deb_up, deb_down;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .pixel_clk (pixel_clk), .reset (reset), .raw (btn_left),  .level (deb_left)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .pixel_clk (pixel_clk), .reset (reset), .raw (btn_right), .level (deb_right)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .pixel_clk (pixel_clk), .reset (reset), .raw (btn_up),    .level (deb_up)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .pixel_clk (pixel_clk), .reset (reset), .raw (btn_down),  .level (deb_down)
    );

    ctrl_state_t        state, state_next;
    logic               latch_en, calc_en, commit_en;
    logic               vsync_q, vsync_prev, frame_edge;
    logic               lat_left, lat_right, lat_up, lat_down, lat_enable;
    logic signed [11:0] dx, dy, sum_x, sum_y;
    logic [9:0]         cand_x, cand_y;
    logic [9:0]         pos_x, pos_y;
    logic [15:0]        frame_cnt;
    logic               tick;

    assign player_x    = pos_x;
    assign player_y    = pos_y;
    assign frame_count = frame_cnt;
    assign frame_tick  = tick;

    // Both vsync history flops reset to the active level so that vsync held
    // active across reset release is not mistaken for a fresh frame edge.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            vsync_q    <= VSYNC_ACTIVE;
            vsync_prev <= VSYNC_ACTIVE;
        end else begin
            vsync_q    <= vsync;
            vsync_prev <= vsync_q;
        end
    end

    assign frame_edge = (vsync_q == VSYNC_ACTIVE) && (vsync_prev != VSYNC_ACTIVE);

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Edges seen outside IDLE are simply ignored: a frame in flight always
    // completes LATCH -> CALC -> COMMIT before another edge is considered.
    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        calc_en    = 1'b0;
        commit_en  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_edge) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                latch_en   = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                calc_en    = 1'b1;
                state_next = COMMIT;
            end
            COMMIT: begin
                commit_en  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Opposite directions cancel; a latched-low enable zeroes both deltas.
    always_comb begin
        dx = '0;
        dy = '0;
        if (lat_enable) begin
            if (lat_right && !lat_left) begin
                dx = STEP_S;
            end else if (lat_left && !lat_right) begin
                dx = -STEP_S;
            end
            if (lat_down && !lat_up) begin
                dy = STEP_S;
            end else if (lat_up && !lat_down) begin
                dy = -STEP_S;
            end
        end
        sum_x = $signed({2'b00, pos_x}) + dx;
        sum_y = $signed({2'b00, pos_y}) + dy;
    end

    // Datapath: button snapshot, clamped candidates and the committed
    // position/frame counter. Outputs only move in COMMIT, which lands a
    // fixed four cycles after the vsync edge, inside vertical blanking.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            lat_left   <= 1'b0;
            lat_right  <= 1'b0;
            lat_up     <= 1'b0;
            lat_down   <= 1'b0;
            lat_enable <= 1'b0;
            cand_x     <= 10'(PLAYER_X0);
            cand_y     <= 10'(PLAYER_Y0);
            pos_x      <= 10'(PLAYER_X0);
            pos_y      <= 10'(PLAYER_Y0);
            frame_cnt  <= '0;
            tick       <= 1'b0;
        end else begin
            if (latch_en) begin
                lat_left   <= deb_left;
                lat_right  <= deb_right;
                lat_up     <= deb_up;
                lat_down   <= deb_down;
                lat_enable <= enable;
            end
            if (calc_en) begin
                cand_x <= clamp_axis(sum_x, X_MIN, X_MAX);
                cand_y <= clamp_axis(sum_y, Y_MIN, Y_MAX);
            end
            if (commit_en) begin
                pos_x     <= cand_x;
                pos_y     <= cand_y;
                frame_cnt <= frame_cnt + 16'd1;
            end
            tick <= commit_en;
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_ctrl
// Self-checking bench for player_ctrl with a short debounce window. A
// frame-level reference model tracks the expected position and frame count.
// -----------------------------------------------------------------------------
module tb_player_ctrl;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        enable;
    logic [3:0]  btn_vec;   // {left, right, up, down}
    logic        btn_left, btn_right, btn_up, btn_down;
    logic [9:0]  player_x, player_y;
    logic [15:0] frame_count;
    logic        frame_tick;

    assign {btn_left, btn_right, btn_up, btn_down} = btn_vec;

    player_ctrl #(
        .STEP            (2),
        .DEBOUNCE_CYCLES (4),
        .VSYNC_ACTIVE    (1'b1)
    ) dut (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .vsync       (vsync),
        .enable      (enable),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .player_x    (player_x),
        .player_y    (player_y),
        .frame_count (frame_count),
        .frame_tick  (frame_tick)
    );

    always #5 pixel_clk = ~pixel_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         mx, my, mcount;
    logic [3:0] cur_btns;
    logic       cur_en;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int dirDelta(input logic neg, input logic pos, input logic en);
        if (!en || (neg == pos)) return 0;
        return pos ? 2 : -2;
    endfunction

    task automatic modelReset();
        mx     = 320;
        my     = 400;
        mcount = 0;
    endtask

    // Present a button/enable setting long enough to pass the debouncer,
    // optionally followed by a short glitch on one button that must be
    // rejected (at most 3 cycles against a 4-cycle window).
    task automatic applyStimulus(input logic [3:0] btns, input logic en,
                                 input int glitch_idx, input int glitch_len);
        @(negedge pixel_clk);
        btn_vec  = btns;
        enable   = en;
        cur_btns = btns;
        cur_en   = en;
        repeat (10) @(negedge pixel_clk);
        if (glitch_idx >= 0) begin
            btn_vec[glitch_idx] = ~btns[glitch_idx];
            repeat (glitch_len) @(negedge pixel_clk);
            btn_vec = btns;
            repeat (8) @(negedge pixel_clk);
        end
    endtask

    // One vsync rising edge; checks every cycle up to one past the commit.
    task automatic runFrame();
        int nx, ny, ncount;
        nx     = clampi(mx + dirDelta(cur_btns[3], cur_btns[2], cur_en), 10, 630);
        ny     = clampi(my + dirDelta(cur_btns[1], cur_btns[0], cur_en), 20, 460);
        ncount = (mcount + 1) % 65536;
        @(negedge pixel_clk);
        vsync = 1'b1;
        @(posedge pixel_clk);
        #1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge pixel_clk);
            #1;
            if (c < 4) begin
                checkOutput("hold_x", 32'(player_x), 32'(mx));
                checkOutput("hold_y", 32'(player_y), 32'(my));
                checkOutput("hold_tick", 32'(frame_tick), 32'd0);
            end else begin
                checkOutput("commit_x", 32'(player_x), 32'(nx));
                checkOutput("commit_y", 32'(player_y), 32'(ny));
                checkOutput("commit_count", 32'(frame_count), 32'(ncount));
                checkOutput("commit_tick", 32'(frame_tick), (c == 4) ? 32'd1 : 32'd0);
            end
        end
        mx     = nx;
        my     = ny;
        mcount = ncount;
        @(negedge pixel_clk);
        vsync = 1'b0;
        repeat (2) @(negedge pixel_clk);
    endtask

    initial begin
        reset   = 1'b1;
        vsync   = 1'b1;
        enable  = 1'b1;
        btn_vec = 4'b0000;
        cur_btns = 4'b0000;
        cur_en   = 1'b1;
        modelReset();

        // Reset with vsync held active: no frame edge on release
        repeat (3) @(negedge pixel_clk);
        reset = 1'b0;
        @(posedge pixel_clk);
        #1;
        checkOutput("rst_x", 32'(player_x), 32'd320);
        checkOutput("rst_y", 32'(player_y), 32'd400);
        checkOutput("rst_count", 32'(frame_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge pixel_clk);
            #1;
            checkOutput("rst_no_tick", 32'(frame_tick), 32'd0);
        end
        @(negedge pixel_clk);
        vsync = 1'b0;
        repeat (2) @(negedge pixel_clk);

        // Movement right over three frames
        applyStimulus(4'b0100, 1'b1, -1, 0);
        repeat (3) runFrame();

        // Reset asserted while the FSM is in CALC: the commit is lost
        @(negedge pixel_clk);
        vsync = 1'b1;
        @(posedge pixel_clk);          // edge E
        repeat (2) @(posedge pixel_clk); // E+1 LATCH, E+2 CALC
        @(negedge pixel_clk);
        reset = 1'b1;
        modelReset();
        @(posedge pixel_clk);
        #1;
        checkOutput("midrst_x", 32'(player_x), 32'd320);
        checkOutput("midrst_y", 32'(player_y), 32'd400);
        checkOutput("midrst_count", 32'(frame_count), 32'd0);
        @(negedge pixel_clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pixel_clk);
            #1;
            checkOutput("midrst_no_tick", 32'(frame_tick), 32'd0);
            checkOutput("midrst_hold_x", 32'(player_x), 32'd320);
        end
        @(negedge pixel_clk);
        vsync = 1'b0;
        applyStimulus(4'b0100, 1'b1, -1, 0);
        runFrame();

        // Drive to the left edge and stay clamped there
        applyStimulus(4'b1000, 1'b1, -1, 0);
        for (int i = 0; i < 160; i++) runFrame();
        checkOutput("left_clamped", 32'(player_x), 32'd10);

        // Drive to the bottom edge
        applyStimulus(4'b0001, 1'b1, -1, 0);
        for (int i = 0; i < 32; i++) runFrame();
        checkOutput("down_clamped", 32'(player_y), 32'd460);

        // Opposite buttons cancel
        applyStimulus(4'b1100, 1'b1, -1, 0);
        repeat (2) runFrame();

        // Short up pulse is rejected, then a held up press moves
        applyStimulus(4'b0000, 1'b1, 1, 3);
        runFrame();
        applyStimulus(4'b0010, 1'b1, -1, 0);
        runFrame();

        // Enable low: position holds, frames still count
        applyStimulus(4'b0100, 1'b0, -1, 0);
        repeat (3) runFrame();

        // Frame counter wrap
        @(negedge pixel_clk);
        force dut.frame_cnt = 16'hFFFF;
        @(posedge pixel_clk);
        #1;
        release dut.frame_cnt;
        mcount = 65535;
        checkOutput("forced_count", 32'(frame_count), 32'd65535);
        runFrame();
        checkOutput("wrap_count", 32'(frame_count), 32'd0);

        // Randomised frames with random buttons, enable and glitches
        for (int i = 0; i < 60; i++) begin
            logic [3:0] b;
            logic       e;
            int         g;
            b = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) != 0);
            g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            applyStimulus(b, e, g, int'($urandom_range(1, 3)));
            runFrame();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
